// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard frame controller.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam logic [7:0] PS2_BRK        = 8'hF0;
    localparam logic [7:0] PS2_PAUSE      = 8'hE1;
    localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;

    // Event record layout: {extended, break, code[7:0]}.
    localparam int EVT_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_e;

endpackage

// File: rtl/fila_eventos_ps2.sv
// Synchronous event FIFO; the head entry is read straight from the storage registers.
module fila_eventos_ps2 #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [PTR_W:0]   cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o;
    // A pop frees the slot in the same edge, so a push into a full queue still lands.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + PTR_W'(1);
            end
            cnt_q <= cnt_q + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/controlador_ps2.sv
// PS/2 keyboard frame receiver: input synchronizers, 11-bit frame FSM with watchdog,
// E0/F0/E1 prefix folding and an event queue toward the consumer.
module controlador_ps2
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int FIFO_DEPTH     = 4,
    parameter int SYNC_STAGES    = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ps2_clk,
    input  logic         ps2_data,
    // evt_valid/evt_ready: the head event moves on a cycle where both are high; while
    // evt_ready is low the head fields and evt_valid hold their values.
    output logic         evt_valid,
    input  logic         evt_ready,
    output logic [7:0]   evt_code,
    output logic         evt_break,
    output logic         evt_extended,
    output logic         frame_err,
    output logic         overflow,
    output logic         busy,
    output frame_state_e dbg_state
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_hist_q;
    logic                   fall;
    logic                   data_s;

    frame_state_e state_q;
    logic [2:0]   bit_cnt_q;
    logic [7:0]   shift_q;
    logic         parity_q;
    logic [WD_W-1:0] wd_q;
    logic         frame_err_q;
    logic         byte_valid_q;

    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic [2:0] skip_q, skip_d;
    logic       push;
    logic       overflow_q;
    logic       fifo_full;
    logic       fifo_empty;
    logic [EVT_W-1:0] head;

    always_ff @(posedge clk) begin
        if (!reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_hist_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
            clk_hist_q  <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign fall   = clk_hist_q && !clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            wd_q         <= '0;
            frame_err_q  <= 1'b0;
            byte_valid_q <= 1'b0;
        end else begin
            frame_err_q  <= 1'b0;
            byte_valid_q <= 1'b0;
            if (state_q == ST_IDLE || fall) begin
                wd_q <= '0;
            end else begin
                wd_q <= wd_q + WD_W'(1);
            end
            if (fall) begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (!data_s) begin
                            state_q   <= ST_DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    ST_DATA: begin
                        shift_q   <= {data_s, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        parity_q <= data_s;
                        state_q  <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (data_s && (^{parity_q, shift_q})) begin
                            byte_valid_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end else if (state_q != ST_IDLE && wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                // Lost clock edge mid-frame: drop it so the next start bit resynchronizes.
                state_q     <= ST_IDLE;
                frame_err_q <= 1'b1;
                wd_q        <= '0;
            end
        end
    end

    always_comb begin
        ext_d  = ext_q;
        brk_d  = brk_q;
        skip_d = skip_q;
        push   = 1'b0;
        if (frame_err_q) begin
            ext_d  = 1'b0;
            brk_d  = 1'b0;
            skip_d = '0;
        end else if (byte_valid_q) begin
            if (skip_q != '0) begin
                skip_d = skip_q - 3'd1;
            end else begin
                unique case (shift_q)
                    PS2_EXT:   ext_d  = 1'b1;
                    PS2_BRK:   brk_d  = 1'b1;
                    PS2_PAUSE: skip_d = PS2_PAUSE_SKIP;
                    8'h00, 8'hFF: begin
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                    default: begin
                        push  = 1'b1;
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            skip_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            skip_q     <= skip_d;
            overflow_q <= push && fifo_full && !(evt_ready && evt_valid);
        end
    end

    fila_eventos_ps2 #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fila (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .data_i  ({ext_q, brk_q, shift_q}),
        .pop_i   (evt_ready),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign evt_valid    = !fifo_empty;
    assign evt_extended = head[9];
    assign evt_break    = head[8];
    assign evt_code     = head[7:0];
    assign frame_err    = frame_err_q;
    assign overflow     = overflow_q;
    assign busy         = (state_q != ST_IDLE);
    assign dbg_state    = state_q;

endmodule
